// File: rtl/ifetch_pcgen_pkg.sv
// Shared fetch-side types and defaults for the icache core port and PC generator.
package ifetch_pcgen_pkg;

  localparam int unsigned SC_LADDRBITS     = 32;
  localparam int unsigned IFETCH_BYTES     = 16;
  localparam int unsigned IFETCH_MAX_OUTST = 4;

  typedef logic [SC_LADDRBITS-1:0] SC_laddr_type;

  typedef struct packed {
    logic [127:0] data;
    logic         fault;
  } I_ictocore_type;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_LIVE,
    RESP_STALE
  } resp_kind_e;

  function automatic SC_laddr_type next_fetch_pc(input SC_laddr_type pc,
                                                 input int unsigned  fetch_bytes);
    SC_laddr_type mask;
    mask = SC_laddr_type'(fetch_bytes - 1);
    return (pc & ~mask) + SC_laddr_type'(fetch_bytes);
  endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// In-order queue of issued fetch PCs awaiting their icache response.
module fetch_pc_fifo
  import ifetch_pcgen_pkg::*;
#(
  parameter int unsigned DEPTH = IFETCH_MAX_OUTST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  SC_laddr_type             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output SC_laddr_type             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  SC_laddr_type  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // A push into a full queue is fine when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_i && full_o && !pop_i))
    else $error("fetch_pc_fifo push while full");

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop_i && empty_o))
    else $error("fetch_pc_fifo pop while empty");

endmodule

// File: rtl/ifetch_pcgen.sv
// Fetch-address generator: issues sequential fetch PCs to the icache, pairs in-order
// responses with their PCs for decode, and discards responses made stale by a redirect.
module ifetch_pcgen
  import ifetch_pcgen_pkg::*;
#(
  parameter SC_laddr_type RESET_PC    = '0,
  parameter int unsigned  FETCH_BYTES = IFETCH_BYTES,
  parameter int unsigned  MAX_OUTST   = IFETCH_MAX_OUTST
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           redirect_valid,
  input  SC_laddr_type   redirect_pc,
  output logic           coretoic_valid,
  input  logic           coretoic_retry,
  output SC_laddr_type   coretoic_pc,
  input  logic           ictocore_valid,
  output logic           ictocore_retry,
  input  I_ictocore_type ictocore,
  output logic           fbuf_valid,
  input  logic           fbuf_retry,
  output I_ictocore_type fbuf_data,
  output SC_laddr_type   fbuf_pc
);

  localparam int unsigned CW      = $clog2(MAX_OUTST) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  SC_laddr_type  pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  resp_kind_e    resp_kind;
  logic          issue_xfer;
  logic          resp_xfer;
  logic          live_pop;
  logic          fifo_push;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  SC_laddr_type  fifo_head;

  always_comb begin
    resp_kind = RESP_NONE;
    if (ictocore_valid && !reset) begin
      if (redirect_valid || (drop_q != '0)) resp_kind = RESP_STALE;
      else                                  resp_kind = RESP_LIVE;
    end
  end

  assign coretoic_valid = !reset && (inflight_q < MAX_CNT);
  assign coretoic_pc    = pc_q;
  assign issue_xfer     = coretoic_valid && !coretoic_retry;

  assign fbuf_valid     = (resp_kind == RESP_LIVE);
  assign fbuf_data      = ictocore;
  assign fbuf_pc        = fifo_head;
  assign ictocore_retry = (resp_kind == RESP_LIVE) && fbuf_retry;

  assign resp_xfer = (resp_kind != RESP_NONE) && !ictocore_retry;
  assign live_pop  = (resp_kind == RESP_LIVE) && !fbuf_retry;
  assign fifo_push = issue_xfer && !redirect_valid;

  always_comb begin
    inflight_d = inflight_q + CW'(issue_xfer) - CW'(resp_xfer);
    pc_d       = pc_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      // Everything still outstanding after this cycle, including a request
      // accepted now with the old PC, must be discarded when it returns.
      drop_d = inflight_d;
    end else begin
      if (issue_xfer) pc_d = next_fetch_pc(pc_q, FETCH_BYTES);
      if ((resp_kind == RESP_STALE) && resp_xfer && (drop_q != '0))
        drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_pc_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_pc_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (pc_q),
    .pop_i       (live_pop),
    .flush_i     (redirect_valid),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  a_live_has_pc: assert property (@(posedge clk) disable iff (reset)
    (resp_kind == RESP_LIVE) |-> !fifo_empty)
    else $error("ifetch_pcgen live response with no outstanding fetch PC");

  a_accounting: assert property (@(posedge clk) disable iff (reset)
    (fifo_count + drop_q) == inflight_q)
    else $error("ifetch_pcgen fifo count + drop count differs from inflight");

  a_inflight_bound: assert property (@(posedge clk) disable iff (reset)
    inflight_q <= MAX_CNT)
    else $error("ifetch_pcgen inflight exceeds MAX_OUTST");

  a_push_room: assert property (@(posedge clk) disable iff (reset)
    fifo_push |-> (!fifo_full || live_pop))
    else $error("ifetch_pcgen issue with PC queue full");

  a_req_hold: assert property (@(posedge clk) disable iff (reset)
    (coretoic_valid && coretoic_retry && !redirect_valid)
      |=> (reset || (coretoic_valid && $stable(coretoic_pc))))
    else $error("ifetch_pcgen request dropped or changed under retry");

endmodule

// File: tb/tb_ifetch_pcgen.sv
// Self-checking bench for ifetch_pcgen: behavioural icache model plus a queue of expected
// (PC, stale) records, driven by a table of stimulus phases and a hand-written reset sequence.
module tb_ifetch_pcgen;
  import ifetch_pcgen_pkg::*;

  localparam SC_laddr_type RST_PC = 32'h0;
  localparam int unsigned  MAXO   = 4;
  localparam int unsigned  LAT    = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           redirect_valid;
  SC_laddr_type   redirect_pc;
  logic           coretoic_valid;
  logic           coretoic_retry;
  SC_laddr_type   coretoic_pc;
  logic           ictocore_valid;
  logic           ictocore_retry;
  I_ictocore_type ictocore;
  logic           fbuf_valid;
  logic           fbuf_retry;
  I_ictocore_type fbuf_data;
  SC_laddr_type   fbuf_pc;

  ifetch_pcgen #(
    .RESET_PC    (RST_PC),
    .FETCH_BYTES (16),
    .MAX_OUTST   (MAXO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .coretoic_valid (coretoic_valid),
    .coretoic_retry (coretoic_retry),
    .coretoic_pc    (coretoic_pc),
    .ictocore_valid (ictocore_valid),
    .ictocore_retry (ictocore_retry),
    .ictocore       (ictocore),
    .fbuf_valid     (fbuf_valid),
    .fbuf_retry     (fbuf_retry),
    .fbuf_data      (fbuf_data),
    .fbuf_pc        (fbuf_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  ready;
    SC_laddr_type pc;
    bit           stale;
    logic [127:0] tag;
  } req_t;

  typedef struct {
    int unsigned  ncyc;
    bit           hold;
    bit           cretry;
    bit           fretry;
    bit           redir;
    SC_laddr_type rpc;
    bit           do_rst;
    int           exp_iss;
  } vec_t;

  req_t         pend[$];
  vec_t         tbl[15];
  int unsigned  cyc;
  SC_laddr_type exp_pc;
  int           n_chk;
  int           n_fail;
  int           iss_cnt;
  bit           ic_hold, fb_ret, ci_ret;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit redir, input SC_laddr_type rpc);
    req_t r;
    bit   exp_cv;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    coretoic_retry = ci_ret;
    fbuf_retry     = fb_ret;
    ictocore_valid = 1'b0;
    ictocore.data  = '0;
    ictocore.fault = 1'b0;
    if (!ic_hold && pend.size() > 0) begin
      if (pend[0].ready <= cyc) begin
        ictocore_valid = 1'b1;
        ictocore.data  = pend[0].tag;
      end
    end
    #1;
    exp_cv = (pend.size() < MAXO);
    check("coretoic_valid", coretoic_valid, exp_cv);
    if (redir) foreach (pend[i]) pend[i].stale = 1'b1;
    if (ictocore_valid) begin
      if (pend[0].stale) begin
        check("stale fbuf_valid", fbuf_valid, 1'b0);
        check("stale ictocore_retry", ictocore_retry, 1'b0);
        void'(pend.pop_front());
      end else begin
        check("live fbuf_valid", fbuf_valid, 1'b1);
        check("live ictocore_retry", ictocore_retry, fb_ret);
        check("fbuf_pc", fbuf_pc, pend[0].pc);
        check("fbuf_data", fbuf_data, ictocore);
        if (!fb_ret) void'(pend.pop_front());
      end
    end else begin
      check("idle fbuf_valid", fbuf_valid, 1'b0);
    end
    if (exp_cv && !ci_ret) begin
      check("coretoic_pc", coretoic_pc, exp_pc);
      r.ready = cyc + LAT;
      r.pc    = exp_pc;
      r.stale = redir;
      r.tag   = {$urandom, $urandom, $urandom, $urandom};
      pend.push_back(r);
      iss_cnt++;
      exp_pc = exp_pc + 32'd16;
    end
    if (redir) exp_pc = rpc;
    cyc++;
  endtask

  task automatic reset_seq();
    @(negedge clk);
    redirect_valid = 1'b0;
    coretoic_retry = 1'b1;
    fbuf_retry     = 1'b0;
    ictocore_valid = 1'b1;
    ictocore.data  = 128'hDEAD;
    #1;
    reset = 1'b1;
    #1;
    check("rst coretoic_valid", coretoic_valid, 1'b0);
    check("rst fbuf_valid", fbuf_valid, 1'b0);
    check("rst ictocore_retry", ictocore_retry, 1'b0);
    @(negedge clk);
    ictocore_valid = 1'b0;
    coretoic_retry = 1'b0;
    check("rst held coretoic_valid", coretoic_valid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend.delete();
    exp_pc = RST_PC;
    #1;
    check("post-rst coretoic_valid", coretoic_valid, 1'b1);
    check("post-rst coretoic_pc", coretoic_pc, RST_PC);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; iss_cnt = 0;
    exp_pc = RST_PC;
    ic_hold = 1'b0; fb_ret = 1'b0; ci_ret = 1'b0;
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    coretoic_retry = 1'b0; fbuf_retry = 1'b0;
    ictocore_valid = 1'b0; ictocore = '0;

    //           ncyc hold cret fret redir rpc           rst exp_iss
    tbl[0]  = '{ 8,   0,   0,   0,   0,    32'h0,        0,  8 };
    tbl[1]  = '{ 6,   1,   0,   0,   0,    32'h0,        0,  2 };
    tbl[2]  = '{ 1,   0,   0,   0,   0,    32'h0,        0,  0 };
    tbl[3]  = '{ 1,   1,   0,   0,   0,    32'h0,        0,  1 };
    tbl[4]  = '{ 3,   1,   0,   0,   0,    32'h0,        0,  0 };
    tbl[5]  = '{ 1,   1,   0,   0,   1,    32'h1000,     0,  0 };
    tbl[6]  = '{ 12,  0,   0,   0,   0,    32'h0,        0, -1 };
    tbl[7]  = '{ 1,   0,   0,   0,   1,    32'h2000,     0,  1 };
    tbl[8]  = '{ 8,   0,   0,   0,   0,    32'h0,        0, -1 };
    tbl[9]  = '{ 5,   0,   0,   1,   0,    32'h0,        0, -1 };
    tbl[10] = '{ 10,  0,   0,   0,   0,    32'h0,        0, -1 };
    tbl[11] = '{ 0,   0,   1,   0,   0,    32'h0,        1, -1 };
    tbl[12] = '{ 1,   0,   0,   0,   1,    32'hFFFF_FFE0, 0,  1 };
    tbl[13] = '{ 8,   0,   0,   0,   0,    32'h0,        0,  8 };
    tbl[14] = '{ 10,  0,   1,   0,   0,    32'h0,        0,  0 };

    repeat (2) @(posedge clk);
    #1;
    check("reset coretoic_valid", coretoic_valid, 1'b0);
    check("reset fbuf_valid", fbuf_valid, 1'b0);
    check("reset ictocore_retry", ictocore_retry, 1'b0);
    reset = 1'b0;
    #1;
    check("first coretoic_pc", coretoic_pc, RST_PC);

    for (int r = 0; r < 15; r++) begin
      iss_cnt = 0;
      if (tbl[r].do_rst) begin
        reset_seq();
      end else begin
        ic_hold = tbl[r].hold;
        ci_ret  = tbl[r].cretry;
        fb_ret  = tbl[r].fretry;
        for (int unsigned k = 0; k < tbl[r].ncyc; k++)
          cycle(tbl[r].redir && (k == 0), tbl[r].rpc);
        if (tbl[r].exp_iss >= 0)
          check($sformatf("row %0d issue count", r), iss_cnt, tbl[r].exp_iss);
      end
    end
    check("all responses drained", pend.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
